// File: rtl/byte_block_demux.sv
// Byte-stream to 128-bit block assembler with key and text channels.
// Each channel fills big-endian, then holds its block until consumed.
module byte_block_demux #(
  parameter int DW     = 8,
  parameter int NBYTES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  input  logic                 in_sel,
  output logic                 in_ready,
  output logic [DW*NBYTES-1:0] key_data,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [DW*NBYTES-1:0] text_data,
  output logic                 text_valid,
  input  logic                 text_ready
);

  localparam int BW = DW * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          st_q   [2];
  state_t          st_d   [2];
  logic [CW-1:0]   cnt_q  [2];
  logic [CW-1:0]   cnt_d  [2];
  logic [BW-1:0]   data_q [2];
  logic [BW-1:0]   data_d [2];
  logic [1:0]      rdy;
  logic            accept;

  assign rdy      = {text_ready, key_ready};
  assign in_ready = ~flush & (st_q[in_sel] == FILL);
  assign accept   = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      data_d[i] = data_q[i];
      if (flush) begin
        st_d[i]   = FILL;
        cnt_d[i]  = '0;
        data_d[i] = '0;
      end else begin
        unique case (st_q[i])
          FILL: begin
            if (accept && (in_sel == i[0])) begin
              data_d[i] = {data_q[i][BW-DW-1:0], in_data};
              if (cnt_q[i] == LAST) begin
                cnt_d[i] = '0;
                st_d[i]  = HOLD;
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
          HOLD: begin
            // data stays put; the next block shifts over it
            if (rdy[i]) st_d[i] = FILL;
          end
          default: st_d[i] = FILL;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        st_q[i]   <= FILL;
        cnt_q[i]  <= '0;
        data_q[i] <= '0;
      end else begin
        st_q[i]   <= st_d[i];
        cnt_q[i]  <= cnt_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign key_data   = data_q[0];
  assign key_valid  = (st_q[0] == HOLD);
  assign text_data  = data_q[1];
  assign text_valid = (st_q[1] == HOLD);

endmodule

// File: tb/tb_byte_block_demux.sv
// Directed bench for byte_block_demux: fill, interleave,
// backpressure, flush and mid-fill reset scenarios.
module tb_byte_block_demux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_sel;
  logic         in_ready;
  logic [127:0] key_data;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] text_data;
  logic         text_valid;
  logic         text_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  byte_block_demux #(.DW(8), .NBYTES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .key_data   (key_data),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .text_data  (text_data),
    .text_valid (text_valid),
    .text_ready (text_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_sel = 1'b0;
    in_data = 8'hEE;
    tick();
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    total++;
    if (key_data !== 128'h0 || text_data !== 128'h0) begin
      bad++;
      $display("FAIL reset_data key=%h text=%h exp=0", key_data, text_data);
    end
    total++;
    if (key_valid !== 1'b0 || text_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid key=%b text=%b exp=0", key_valid, text_valid);
    end
    #0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_key_fill();
    for (int i = 0; i < 15; i++) send(1'b0, 8'(i));
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL key_early got=%b exp=0", key_valid);
    end
    send(1'b0, 8'h0F);
    in_valid = 1'b0;
    total++;
    if (key_valid !== 1'b1) begin
      bad++;
      $display("FAIL key_valid got=%b exp=1", key_valid);
    end
    total++;
    if (key_data !== 128'h000102030405060708090A0B0C0D0E0F) begin
      bad++;
      $display("FAIL key_data got=%h exp=%h", key_data,
               128'h000102030405060708090A0B0C0D0E0F);
    end
    total++;
    if (text_valid !== 1'b0 || text_data !== 128'h0) begin
      bad++;
      $display("FAIL text_untouched v=%b d=%h exp=0", text_valid, text_data);
    end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL key_release got=%b exp=0", key_valid);
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 5; i++) send(1'b0, 8'hA0 + 8'(i));
    for (int i = 0; i < 16; i++) send(1'b1, 8'h10 + 8'(i));
    in_valid = 1'b0;
    total++;
    if (text_valid !== 1'b1 || key_valid !== 1'b0) begin
      bad++;
      $display("FAIL ilv_text_valid t=%b k=%b exp=1/0", text_valid, key_valid);
    end
    total++;
    if (text_data !== 128'h101112131415161718191A1B1C1D1E1F) begin
      bad++;
      $display("FAIL ilv_text_data got=%h exp=%h", text_data,
               128'h101112131415161718191A1B1C1D1E1F);
    end
    text_ready = 1'b1;
    for (int i = 5; i < 16; i++) send(1'b0, 8'hA0 + 8'(i));
    in_valid = 1'b0;
    text_ready = 1'b0;
    total++;
    if (key_valid !== 1'b1 || text_valid !== 1'b0) begin
      bad++;
      $display("FAIL ilv_key_valid k=%b t=%b exp=1/0", key_valid, text_valid);
    end
    total++;
    if (key_data !== 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF) begin
      bad++;
      $display("FAIL ilv_key_data got=%h exp=%h", key_data,
               128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL ilv_key_once got=%b exp=0", key_valid);
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    for (int i = 0; i < 16; i++) send(1'b0, 8'h30 + 8'(i));
    in_data = 8'h55;
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      #0;
      if (in_ready !== 1'b0 ||
          key_data !== 128'h303132333435363738393A3B3C3D3E3F) stalls++;
      tick();
    end
    total++;
    if (stalls != 0) begin
      bad++;
      $display("FAIL bp_hold bad_cycles=%0d exp=0", stalls);
    end
    key_ready = 1'b1;
    #0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_release_ready got=%b exp=0", in_ready);
    end
    tick();
    key_ready = 1'b0;
    total++;
    if (key_valid !== 1'b0 ||
        key_data !== 128'h303132333435363738393A3B3C3D3E3F) begin
      bad++;
      $display("FAIL bp_refused v=%b d=%h exp=0/%h", key_valid, key_data,
               128'h303132333435363738393A3B3C3D3E3F);
    end
    tick();
    total++;
    if (key_data !== 128'h3132333435363738393A3B3C3D3E3F55) begin
      bad++;
      $display("FAIL bp_first_byte got=%h exp=%h", key_data,
               128'h3132333435363738393A3B3C3D3E3F55);
    end
    for (int i = 0; i < 15; i++) send(1'b0, 8'h60 + 8'(i));
    in_valid = 1'b0;
    total++;
    if (key_valid !== 1'b1 ||
        key_data !== 128'h55606162636465666768696A6B6C6D6E) begin
      bad++;
      $display("FAIL bp_next_block v=%b d=%h exp=1/%h", key_valid, key_data,
               128'h55606162636465666768696A6B6C6D6E);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) send(1'b1, 8'hE0 + 8'(i));
    flush = 1'b1;
    in_valid = 1'b1;
    in_sel = 1'b1;
    in_data = 8'h77;
    #0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready got=%b exp=0", in_ready);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (key_valid !== 1'b0 || text_valid !== 1'b0 ||
        key_data !== 128'h0 || text_data !== 128'h0) begin
      bad++;
      $display("FAIL flush_clear kv=%b tv=%b kd=%h td=%h exp=0",
               key_valid, text_valid, key_data, text_data);
    end
    for (int i = 0; i < 15; i++) send(1'b1, 8'h80 + 8'(i));
    total++;
    if (text_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_early got=%b exp=0", text_valid);
    end
    send(1'b1, 8'h8F);
    in_valid = 1'b0;
    total++;
    if (text_valid !== 1'b1 ||
        text_data !== 128'h808182838485868788898A8B8C8D8E8F) begin
      bad++;
      $display("FAIL flush_refill v=%b d=%h exp=1/%h", text_valid, text_data,
               128'h808182838485868788898A8B8C8D8E8F);
    end
    text_ready = 1'b1;
    tick();
    text_ready = 1'b0;
  endtask

  task automatic test_sync_reset();
    for (int i = 0; i < 9; i++) send(1'b0, 8'h90 + 8'(i));
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (key_data !== 128'h0) begin
      bad++;
      $display("FAIL srst_data got=%h exp=0", key_data);
    end
    for (int i = 0; i < 15; i++) send(1'b0, 8'hC0 + 8'(i));
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL srst_early got=%b exp=0", key_valid);
    end
    send(1'b0, 8'hCF);
    in_valid = 1'b0;
    total++;
    if (key_valid !== 1'b1 ||
        key_data !== 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF) begin
      bad++;
      $display("FAIL srst_block v=%b d=%h exp=1/%h", key_valid, key_data,
               128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_data = 8'h00;
    in_valid = 1'b0;
    in_sel = 1'b0;
    key_ready = 1'b0;
    text_ready = 1'b0;
    test_reset();
    test_key_fill();
    test_interleave();
    test_back_to_back();
    test_flush();
    test_sync_reset();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
